// File: rtl/aes_pkg.sv
// Shared types, constants and GF(2^8) helpers for the iterative AES core.
// Byte 0 of a block sits at [127:120]; columns are 32-bit words, MSB first.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE,
    KEXP,
    ROUND,
    DONE
  } aes_st_e;

  localparam logic [0:9][7:0] RCON = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic int nk_of(input int kb);
    return kb / 32;
  endfunction

  function automatic int nr_of(input int kb);
    return nk_of(kb) + 6;
  endfunction

  function automatic int nw_of(input int kb);
    return 4 * (nr_of(kb) + 1);
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mixcolumn(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {b0, b1, b2, b3};
  endfunction

  function automatic logic [127:0] mixcolumns(
    input logic [127:0] s
  );
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      o[127-32*c -: 32] = mixcolumn(s[127-32*c -: 32]);
    return o;
  endfunction

  // Row r of column c takes the byte from column (c+r)%4.
  function automatic logic [127:0] shiftrows(
    input logic [127:0] s
  );
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] =
          s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, purely combinational byte lookup.
// Table row n holds outputs for inputs 8'hn0..8'hnf.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign y = SBOX[a];

endmodule

// File: rtl/aes_iter_core.sv
// Iterative AES encryptor: one round per clock, key schedule
// expanded once into a word store and reused on warm accepts.
module aes_iter_core
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        plain_text,
  input  logic [KEY_BITS-1:0] c_key,
  input  logic                key_reuse,
  output logic [127:0]        dataout,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy
);

  localparam int NK = nk_of(KEY_BITS);
  localparam int NR = nr_of(KEY_BITS);
  localparam int NW = nw_of(KEY_BITS);
  localparam int IW = 6;
  localparam int RW = 4;

  aes_st_e st_q, st_d;

  logic [127:0]  state_q;
  logic [127:0]  dout_q;
  logic          key_valid_q;
  logic [IW-1:0] idx_q;
  logic [RW-1:0] round_q;
  logic [2:0]    kpos_q;
  logic [3:0]    rci_q;
  logic [31:0]   w_q [NW];

  logic          accept;
  logic          warm;
  logic [127:0]  rk0;
  logic          kexp_last;
  logic          rnd_last;

  logic [31:0]   prev_w;
  logic [31:0]   old_w;
  logic [31:0]   sw_in;
  logic [31:0]   sw_out;
  logic [31:0]   t_w;
  logic [31:0]   new_w;

  logic [127:0]  sb;
  logic [127:0]  sr;
  logic [127:0]  mc;
  logic [127:0]  rk;
  logic [127:0]  rnd_out;

  assign accept = in_valid && (st_q == IDLE);
  assign warm   = key_reuse && key_valid_q;
  assign rk0    = warm
                ? {w_q[0], w_q[1], w_q[2], w_q[3]}
                : c_key[KEY_BITS-1 -: 128];

  assign kexp_last = idx_q == IW'(NW - 1);
  assign rnd_last  = round_q == RW'(NR);

  assign prev_w = w_q[idx_q - IW'(1)];
  assign old_w  = w_q[idx_q - IW'(NK)];
  assign sw_in  = (kpos_q == 3'd0)
                ? {prev_w[23:0], prev_w[31:24]}
                : prev_w;

  for (genvar g = 0; g < 4; g++) begin : g_sw
    aes_sbox u_sbox (
      .a (sw_in[31-8*g -: 8]),
      .y (sw_out[31-8*g -: 8])
    );
  end

  // Schedule word mix: RotWord+Rcon on period start, extra SubWord mid-period for 256-bit keys.
  always_comb begin
    t_w = prev_w;
    unique case (1'b1)
      (kpos_q == 3'd0):
        t_w = sw_out ^ {RCON[rci_q - 4'd1], 24'h0};
      (NK == 8 && kpos_q == 3'd4):
        t_w = sw_out;
      default:
        t_w = prev_w;
    endcase
  end

  assign new_w = old_w ^ t_w;

  for (genvar g = 0; g < 16; g++) begin : g_sb
    aes_sbox u_sbox (
      .a (state_q[127-8*g -: 8]),
      .y (sb[127-8*g -: 8])
    );
  end

  assign sr = shiftrows(sb);
  assign mc = mixcolumns(sr);

  for (genvar j = 0; j < 4; j++) begin : g_rk
    assign rk[127-32*j -: 32] =
      w_q[{round_q, 2'b00} + IW'(j)];
  end

  assign rnd_out = (rnd_last ? sr : mc) ^ rk;

  // Control state register.
  always_ff @(posedge clock) begin
    if (reset) st_q <= IDLE;
    else       st_q <= st_d;
  end

  // Next state and handshake outputs.
  always_comb begin
    st_d      = st_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (st_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) st_d = warm ? ROUND : KEXP;
      end
      KEXP: begin
        busy = 1'b1;
        if (kexp_last) st_d = ROUND;
      end
      ROUND: begin
        busy = 1'b1;
        if (rnd_last) st_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  // Block state, counters and result register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= '0;
      dout_q      <= '0;
      key_valid_q <= 1'b0;
      idx_q       <= '0;
      round_q     <= '0;
      kpos_q      <= '0;
      rci_q       <= '0;
    end else begin
      if (accept) begin
        state_q <= plain_text ^ rk0;
        if (warm) begin
          round_q <= RW'(1);
        end else begin
          key_valid_q <= 1'b0;
          idx_q       <= IW'(NK);
          kpos_q      <= '0;
          rci_q       <= 4'd1;
        end
      end
      if (st_q == KEXP) begin
        idx_q <= idx_q + IW'(1);
        if (kpos_q == 3'(NK - 1)) begin
          kpos_q <= '0;
          rci_q  <= rci_q + 4'd1;
        end else begin
          kpos_q <= kpos_q + 3'd1;
        end
        if (kexp_last) begin
          key_valid_q <= 1'b1;
          round_q     <= RW'(1);
        end
      end
      if (st_q == ROUND) begin
        state_q <= rnd_out;
        round_q <= round_q + RW'(1);
        if (rnd_last) dout_q <= rnd_out;
      end
    end
  end

  // Round-key word store: loaded on cold accept, extended one word per KEXP cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (accept && !warm) begin
        for (int i = 0; i < NK; i++)
          w_q[i] <= c_key[KEY_BITS-1-32*i -: 32];
      end else if (st_q == KEXP) begin
        w_q[idx_q] <= new_w;
      end
    end
  end

  assign dataout = dout_q;

endmodule
